cache_mem_arbiter: RTL and testbench
====================================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- ADDR_W, 32, address width
- DATA_W, 32, RAM word width
- BEATS, 4, words per cache line
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, single clock
- rst_n, in, 1, asynchronous active-low reset
- ic_rd_req_i, in, 1, icache line-refill request, level-held
- ic_rd_addr_i, in, ADDR_W, icache refill address
- ic_rd_rdy_o, out, 1, icache refill beat valid
- dc_rd_req_i, in, 1, dcache line-refill request, level-held
- dc_rd_addr_i, in, ADDR_W, dcache refill address
- dc_rd_rdy_o, out, 1, dcache refill beat valid
- dc_wr_req_i, in, 1, dcache write-back request, level-held
- dc_wr_addr_i, in, ADDR_W, write-back address
- dc_wr_data_i, in, DATA_W*BEATS, write-back line, word k at bits [32k+31:32k]
- dc_wr_rdy_o, out, 1, write-back complete pulse
- rd_data_o, out, DATA_W, shared refill beat data
- rd_num_o, out, 3, refill beat index
- ram_wr_en_o, out, 4, RAM byte write enables
- ram_wr_addr_o, out, ADDR_W, RAM write address
- ram_wr_data_o, out, DATA_W, RAM write data
- ram_rd_addr_o, out, ADDR_W, RAM read address
- ram_rd_data_i, in, DATA_W, RAM read data, one-cycle synchronous latency
REQ-003 SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.

Function
REQ-004 SHALL implement FSM IDLE -> RD or WR -> DONE -> IDLE; requests are sampled only in IDLE.
REQ-005 SHALL use grant priority in IDLE: dc_wr_req_i first; then round-robin between ic_rd_req_i and dc_rd_req_i using a last-grant pointer (reset value: dcache, so icache wins the first tie).
REQ-006 SHALL, at the grant edge, latch the granted requester and base = {addr[ADDR_W-1:4], 4'b0}; addr[3:0] is ignored.
REQ-007 RD SHALL last BEATS+1 cycles with counter cnt = 0..4:
- for cnt 0..3, ram_rd_addr_o = base + 4*cnt;
- for cnt 1..4, the granted rd_rdy_o = 1, rd_num_o = cnt-1, and rd_data_o = ram_rd_data_i (combinational).
REQ-008 WR SHALL last BEATS cycles with cnt = 0..3: ram_wr_en_o = 4'hF, ram_wr_addr_o = base + 4*cnt, ram_wr_data_o = word cnt of the latched line.
REQ-009 SHALL latch dc_wr_data_i at the grant edge, so later changes to the input do not affect the burst.
REQ-010 DONE SHALL last exactly one cycle and ignore all requests:
- after WR, dc_wr_rdy_o = 1 for that single cycle;
- after RD, no strobe is issued.
REQ-011 Outside the active cycles of REQ-007/008, ram_wr_en_o, all rdy outputs and rd_num_o SHALL be 0; addresses and write data SHALL be 0.
REQ-012 Latency: request high in an IDLE cycle T -> first RAM access in T+1; read beats T+2..T+5, DONE T+6; write DONE T+5.
REQ-013 A request deasserted mid-burst SHALL NOT abort the burst; the burst runs to completion.
REQ-014 Requesters SHALL deassert by the DONE cycle; a request still held in the following IDLE cycle is treated as a new request.
REQ-015 The only rdy asserted SHALL be the granted requester's; ic_rd_rdy_o and dc_rd_rdy_o SHALL never be high together.
REQ-016 Beat addresses SHALL never carry past the line boundary, because base is line-aligned.

Reset
REQ-017 On rst_n low, the block SHALL immediately:
- enter IDLE;
- clear cnt, base and latched data;
- set the last-grant pointer to dcache;
- drive all outputs to 0.
REQ-018 Reset asserted mid-burst SHALL abort the burst with no further rdy pulse or RAM write; after release, the block SHALL return to IDLE.

Verification
REQ-019 Icache refill, ic addr 0x0000_1234, RAM word at A = A: ic_rd_rdy_o high 4 cycles, rd_num_o 0,1,2,3, rd_data_o 0x1230, 0x1234, 0x1238, 0x123C.
REQ-020 Write-back, addr 0x80, line 0xDDDD…_CCCC…_BBBB…_AAAA…: RAM writes 0x80=AAAA…, 0x84=BBBB…, 0x88=CCCC…, 0x8C=DDDD…, each with en 4'hF; dc_wr_rdy_o one pulse at T+5.
REQ-021 dc_wr_req_i and dc_rd_req_i raised together: write burst completes first, read burst starts in the IDLE cycle after DONE.
REQ-022 ic and dc read requests held continuously: grants alternate ic, dc, ic, dc; each completes in 7 cycles.
REQ-023 rst_n pulsed low during read beat 2: no rdy afterwards, all outputs 0; the next request is served from cnt = 0.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache line refills and dcache write-backs onto one
// single-port RAM with one-cycle synchronous read latency.
module cache_mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned BEATS  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ic_rd_req_i,
   input  logic [ADDR_W-1:0]         ic_rd_addr_i,
   output logic                      ic_rd_rdy_o,
   input  logic                      dc_rd_req_i,
   input  logic [ADDR_W-1:0]         dc_rd_addr_i,
   output logic                      dc_rd_rdy_o,
   input  logic                      dc_wr_req_i,
   input  logic [ADDR_W-1:0]         dc_wr_addr_i,
   input  logic [DATA_W*BEATS-1:0]   dc_wr_data_i,
   output logic                      dc_wr_rdy_o,
   output logic [DATA_W-1:0]         rd_data_o,
   output logic [2:0]                rd_num_o,
   output logic [3:0]                ram_wr_en_o,
   output logic [ADDR_W-1:0]         ram_wr_addr_o,
   output logic [DATA_W-1:0]         ram_wr_data_o,
   output logic [ADDR_W-1:0]         ram_rd_addr_o,
   input  logic [DATA_W-1:0]         ram_rd_data_i
);

   localparam int unsigned LINE_W = DATA_W * BEATS;
   localparam int unsigned CNT_W  = 3;
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(4'hF);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic                gnt_dc_q, gnt_dc_d;
   logic                last_dc_q, last_dc_d;
   logic                is_wr_q, is_wr_d;

   logic [ADDR_W-1:0]   beat_addr;
   logic [DATA_W-1:0]   wr_word;

   // State register; last-grant pointer resets to dcache so icache wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         base_q    <= '0;
         line_q    <= '0;
         gnt_dc_q  <= 1'b0;
         last_dc_q <= 1'b1;
         is_wr_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         base_q    <= base_d;
         line_q    <= line_d;
         gnt_dc_q  <= gnt_dc_d;
         last_dc_q <= last_dc_d;
         is_wr_q   <= is_wr_d;
      end
   end

   assign beat_addr = base_q + (ADDR_W'(cnt_q) << 2);

   // Select the write-back word for the current beat
   always_comb begin
      wr_word = '0;
      for (int unsigned k = 0; k < BEATS; k++) begin
         if (cnt_q == CNT_W'(k)) wr_word = line_q[k*DATA_W +: DATA_W];
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      base_d        = base_q;
      line_d        = line_q;
      gnt_dc_d      = gnt_dc_q;
      last_dc_d     = last_dc_q;
      is_wr_d       = is_wr_q;
      ic_rd_rdy_o   = 1'b0;
      dc_rd_rdy_o   = 1'b0;
      dc_wr_rdy_o   = 1'b0;
      rd_data_o     = '0;
      rd_num_o      = '0;
      ram_wr_en_o   = '0;
      ram_wr_addr_o = '0;
      ram_wr_data_o = '0;
      ram_rd_addr_o = '0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (dc_wr_req_i) begin
               state_d = S_WR;
               is_wr_d = 1'b1;
               base_d  = dc_wr_addr_i & LINE_MASK;
               line_d  = dc_wr_data_i;
            end else if (ic_rd_req_i && (!dc_rd_req_i || last_dc_q)) begin
               state_d   = S_RD;
               is_wr_d   = 1'b0;
               gnt_dc_d  = 1'b0;
               last_dc_d = 1'b0;
               base_d    = ic_rd_addr_i & LINE_MASK;
            end else if (dc_rd_req_i) begin
               state_d   = S_RD;
               is_wr_d   = 1'b0;
               gnt_dc_d  = 1'b1;
               last_dc_d = 1'b1;
               base_d    = dc_rd_addr_i & LINE_MASK;
            end
         end

         // Address phase leads the data phase by one cycle (RAM read latency)
         S_RD: begin
            if (cnt_q < CNT_W'(BEATS)) ram_rd_addr_o = beat_addr;
            if (cnt_q != '0) begin
               ic_rd_rdy_o = !gnt_dc_q;
               dc_rd_rdy_o = gnt_dc_q;
               rd_num_o    = cnt_q - 3'd1;
               rd_data_o   = ram_rd_data_i;
            end
            if (cnt_q == CNT_W'(BEATS)) state_d = S_DONE;
            else                        cnt_d   = cnt_q + 3'd1;
         end

         S_WR: begin
            ram_wr_en_o   = 4'hF;
            ram_wr_addr_o = beat_addr;
            ram_wr_data_o = wr_word;
            if (cnt_q == CNT_W'(BEATS - 1)) state_d = S_DONE;
            else                            cnt_d   = cnt_q + 3'd1;
         end

         S_DONE: begin
            dc_wr_rdy_o = is_wr_q;
            state_d     = S_IDLE;
            cnt_d       = '0;
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: refill, write-back, priority,
// round-robin and mid-burst reset, against hand-computed expectations.
module tb_cache_mem_arbiter;

   logic         clk;
   logic         rst_n;
   logic         ic_rd_req;
   logic [31:0]  ic_rd_addr;
   logic         ic_rd_rdy;
   logic         dc_rd_req;
   logic [31:0]  dc_rd_addr;
   logic         dc_rd_rdy;
   logic         dc_wr_req;
   logic [31:0]  dc_wr_addr;
   logic [127:0] dc_wr_data;
   logic         dc_wr_rdy;
   logic [31:0]  rd_data;
   logic [2:0]   rd_num;
   logic [3:0]   ram_wr_en;
   logic [31:0]  ram_wr_addr;
   logic [31:0]  ram_wr_data;
   logic [31:0]  ram_rd_addr;
   logic [31:0]  ram_rd_data;

   int n_checks = 0;
   int n_errors = 0;

   cache_mem_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ic_rd_req_i   (ic_rd_req),
      .ic_rd_addr_i  (ic_rd_addr),
      .ic_rd_rdy_o   (ic_rd_rdy),
      .dc_rd_req_i   (dc_rd_req),
      .dc_rd_addr_i  (dc_rd_addr),
      .dc_rd_rdy_o   (dc_rd_rdy),
      .dc_wr_req_i   (dc_wr_req),
      .dc_wr_addr_i  (dc_wr_addr),
      .dc_wr_data_i  (dc_wr_data),
      .dc_wr_rdy_o   (dc_wr_rdy),
      .rd_data_o     (rd_data),
      .rd_num_o      (rd_num),
      .ram_wr_en_o   (ram_wr_en),
      .ram_wr_addr_o (ram_wr_addr),
      .ram_wr_data_o (ram_wr_data),
      .ram_rd_addr_o (ram_rd_addr),
      .ram_rd_data_i (ram_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: word at address A holds A, one-cycle read latency
   always @(posedge clk) ram_rd_data <= ram_rd_addr;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic any_out();
      return |{ic_rd_rdy, dc_rd_rdy, dc_wr_rdy, rd_data, rd_num,
               ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      ic_rd_req  = 1'b0;
      ic_rd_addr = '0;
      dc_rd_req  = 1'b0;
      dc_rd_addr = '0;
      dc_wr_req  = 1'b0;
      dc_wr_addr = '0;
      dc_wr_data = '0;
      repeat (2) tick();
      check("reset_outputs", 64'(any_out()), 64'd0);
      rst_n = 1'b1;
      tick();

      // Icache refill, addr low nibble ignored; request dropped mid-burst
      ic_rd_req  = 1'b1;
      ic_rd_addr = 32'h0000_1234;
      tick();
      check("ic_t1_rd_addr", 64'(ram_rd_addr), 64'h1230);
      check("ic_t1_rdy", 64'(ic_rd_rdy), 64'd0);
      ic_rd_req = 1'b0;
      for (int b = 0; b < 4; b++) begin
         tick();
         check("ic_beat_rdy", 64'({ic_rd_rdy, dc_rd_rdy}), 64'b10);
         check("ic_beat_num", 64'(rd_num), 64'(b));
         check("ic_beat_data", 64'(rd_data), 64'(32'h1230 + 32'(4 * b)));
         check("ic_beat_next_addr", 64'(ram_rd_addr),
               (b < 3) ? 64'(32'h1234 + 32'(4 * b)) : 64'd0);
      end
      tick();
      check("ic_done_quiet", 64'(any_out()), 64'd0);
      tick();

      // Write-back; input line changes after grant must not leak into the burst
      dc_wr_req  = 1'b1;
      dc_wr_addr = 32'h80;
      dc_wr_data = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
      tick();
      dc_wr_req  = 1'b0;
      dc_wr_data = {4{32'h1111_1111}};
      for (int b = 0; b < 4; b++) begin
         if (b > 0) tick();
         check("wb_en", 64'(ram_wr_en), 64'hF);
         check("wb_addr", 64'(ram_wr_addr), 64'(32'h80 + 32'(4 * b)));
         check("wb_data", 64'(ram_wr_data), 64'(32'hAAAA_AAAA + 32'(b) * 32'h1111_1111));
         check("wb_rdy_early", 64'(dc_wr_rdy), 64'd0);
      end
      tick();
      check("wb_done_rdy", 64'(dc_wr_rdy), 64'd1);
      check("wb_done_en", 64'(ram_wr_en), 64'd0);
      tick();
      check("wb_after_quiet", 64'(any_out()), 64'd0);

      // Write and dcache read together: write first, read granted in next IDLE
      dc_wr_req  = 1'b1;
      dc_wr_addr = 32'h100;
      dc_wr_data = {4{32'h5A5A_5A5A}};
      dc_rd_req  = 1'b1;
      dc_rd_addr = 32'h2008;
      tick();
      check("pri_t1_wr_en", 64'(ram_wr_en), 64'hF);
      check("pri_t1_rd_addr", 64'(ram_rd_addr), 64'd0);
      dc_wr_req = 1'b0;
      repeat (4) tick();
      check("pri_t5_wr_rdy", 64'(dc_wr_rdy), 64'd1);
      check("pri_t5_dc_rdy", 64'(dc_rd_rdy), 64'd0);
      tick();
      check("pri_t6_idle", 64'(any_out()), 64'd0);
      tick();
      check("pri_t7_rd_addr", 64'(ram_rd_addr), 64'h2000);
      dc_rd_req = 1'b0;
      tick();
      check("pri_t8_rdy", 64'({ic_rd_rdy, dc_rd_rdy}), 64'b01);
      check("pri_t8_data", 64'(rd_data), 64'h2000);
      repeat (5) tick();

      // Both read requests held: grants alternate ic, dc, ic, dc every 7 cycles
      ic_rd_req  = 1'b1;
      ic_rd_addr = 32'h3000;
      dc_rd_req  = 1'b1;
      dc_rd_addr = 32'h4008;
      for (int g = 0; g < 4; g++) begin
         tick();
         check("rr_addr", 64'(ram_rd_addr), (g % 2 == 0) ? 64'h3000 : 64'h4000);
         check("rr_addr_cycle_rdy", 64'({ic_rd_rdy, dc_rd_rdy}), 64'b00);
         tick();
         check("rr_grant", 64'({ic_rd_rdy, dc_rd_rdy}), (g % 2 == 0) ? 64'b10 : 64'b01);
         check("rr_data", 64'(rd_data), (g % 2 == 0) ? 64'h3000 : 64'h4000);
         if (g < 3) repeat (5) tick();
      end
      ic_rd_req = 1'b0;
      dc_rd_req = 1'b0;
      repeat (6) tick();
      check("rr_end_quiet", 64'(any_out()), 64'd0);

      // Reset during read beat 2 aborts; pointer returns to dcache
      ic_rd_req  = 1'b1;
      ic_rd_addr = 32'h5000;
      tick();
      ic_rd_req = 1'b0;
      repeat (3) tick();
      check("rst_pre_num", 64'(rd_num), 64'd2);
      rst_n = 1'b0;
      #1;
      check("rst_async_quiet", 64'(any_out()), 64'd0);
      tick();
      check("rst_held_quiet", 64'(any_out()), 64'd0);
      rst_n = 1'b1;
      tick();
      check("rst_after_quiet", 64'(any_out()), 64'd0);
      ic_rd_req  = 1'b1;
      ic_rd_addr = 32'h7004;
      dc_rd_req  = 1'b1;
      dc_rd_addr = 32'h6000;
      tick();
      check("post_rst_addr", 64'(ram_rd_addr), 64'h7000);
      ic_rd_req = 1'b0;
      dc_rd_req = 1'b0;
      tick();
      check("post_rst_rdy", 64'({ic_rd_rdy, dc_rd_rdy}), 64'b10);
      check("post_rst_num", 64'(rd_num), 64'd0);
      check("post_rst_data", 64'(rd_data), 64'h7000);
      repeat (5) tick();
      check("final_quiet", 64'(any_out()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
